// File: rtl/jk_seq_pkg.sv
// Shared op codes and FSM encoding for the JK counter sequencer.
package jk_seq_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_UP    = 2'b01,
    OP_DOWN  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/jkff.sv
// Single JK flip-flop cell with synchronous active-high reset.
module jkff (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_counter_seq.sv
// Command sequencer driving a bank of jkff cells: load, clear, or count up/down L steps.
// Optional abort input is enabled by defining JK_SEQ_ABORT_EN.
module jk_counter_seq
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_len,
`ifdef JK_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  // Command port: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only in IDLE outside reset, so
  // the initiator must hold cmd_valid and the fields stable until then.

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic             dir_up;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] step_mask;
  logic             accept;
  logic             abort_hit;
  logic             stepping;
  logic             step_wraps;
  op_t              op;

`ifdef JK_SEQ_ABORT_EN
  assign abort_hit = abort & (state == S_RUN);
`else
  assign abort_hit = 1'b0;
`endif

  assign op         = op_t'(cmd_op);
  assign cmd_ready  = (state == S_IDLE) & ~rst;
  assign accept     = cmd_valid & cmd_ready;
  assign stepping   = (state == S_RUN) & ~abort_hit;
  assign step_wraps = dir_up ? (&q) : ~(|q);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  // Bit i toggles when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    step_mask    = '0;
    step_mask[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      step_mask[i] = step_mask[i-1] & (dir_up ? q[i-1] : ~q[i-1]);
    end
  end

  always_comb begin
    j = '0;
    k = '0;
    if (accept) begin
      case (op)
        OP_LOAD: begin
          j = cmd_data;
          k = ~cmd_data;
        end
        OP_CLEAR: k = '1;
        default: ;
      endcase
    end else if (stepping) begin
      j = step_mask;
      k = step_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      dir_up    <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      wrap <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            dir_up <= (op == OP_UP);
            if ((op == OP_UP || op == OP_DOWN) && cmd_len != '0) begin
              remaining <= cmd_len;
              state     <= S_RUN;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (abort_hit) begin
            remaining <= '0;
            state     <= S_DONE;
          end else begin
            remaining <= remaining - 1'b1;
            wrap      <= step_wraps;
            if (remaining == CNT_W'(1)) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jkff u_ff (
      .clk (clk),
      .rst (rst),
      .j   (j[i]),
      .k   (k[i]),
      .q   (q[i])
    );
  end

endmodule
